// File: rtl/pwm_capture_if.sv
// Peripheral register bus shared by the PWM generator and capture blocks.
// The master drives strobes, address and data; the slave returns read data.
interface pwm_capture_if;
    logic        re_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;

    modport master (output re_i, we_i, addr_i, wdata_i, be_i, input rdata_o);
    modport slave  (input re_i, we_i, addr_i, wdata_i, be_i, output rdata_o);
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: synchronises pwm_i, measures period and high time in
// prescaled ticks, and publishes them through a small register map.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pwm_capture_if.slave bus,
    input  logic         pwm_i,
    output logic         intr_o
);
    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    logic                   r_en, r_ie, r_oneshot;
    logic [CNT_W-1:0]       r_divisor;
    logic [CNT_W-1:0]       r_period, r_high, r_hi_latch;
    logic [CNT_W-1:0]       r_pre, r_cnt;
    logic                   r_valid, r_ovf, r_intr;

    logic                   w_sync, w_rise, w_fall;
    logic [CNT_W-1:0]       w_div, w_pre_inc, w_cnt_inc;
    logic                   w_tick, w_first_tick, w_cnt_max;
    logic                   w_wr, w_wr_ctrl, w_wr_div, w_wr_stat;
    logic                   w_unused;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_i};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;

    // The edge cycle counts as the first prescaler cycle, so with D=1 it already ticks.
    assign w_div        = (r_divisor == '0) ? ONE : r_divisor;
    assign w_pre_inc    = r_pre + ONE;
    assign w_tick       = (w_pre_inc >= w_div);
    assign w_first_tick = (w_div == ONE);
    assign w_cnt_max    = &r_cnt;
    assign w_cnt_inc    = w_cnt_max ? r_cnt : r_cnt + ONE;

    assign w_wr      = bus.we_i & ~bus.re_i;
    assign w_wr_ctrl = w_wr && (bus.addr_i == 8'h00);
    assign w_wr_div  = w_wr && (bus.addr_i == 8'h04);
    assign w_wr_stat = w_wr && (bus.addr_i == 8'h10);
    assign w_unused  = ^{bus.be_i, bus.wdata_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_divisor  <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_hi_latch <= '0;
            r_pre      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en      <= bus.wdata_i[0];
                r_ie      <= bus.wdata_i[1];
                r_oneshot <= bus.wdata_i[2];
            end
            if (w_wr_div) begin
                r_divisor <= bus.wdata_i[CNT_W-1:0];
            end
            // W1C clears sit before the hardware sets below so a same-cycle set wins.
            if (w_wr_stat) begin
                if (bus.wdata_i[0]) r_valid <= 1'b0;
                if (bus.wdata_i[1]) r_ovf   <= 1'b0;
            end
            r_intr <= r_ie & (r_valid | r_ovf);

            if (!r_en) begin
                r_state <= IDLE;
                r_pre   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= WAIT_RISE;
                        r_pre   <= '0;
                        r_cnt   <= '0;
                    end
                    WAIT_RISE: begin
                        if (w_rise) begin
                            r_state <= MEAS_HIGH;
                            r_pre   <= w_first_tick ? '0 : ONE;
                            r_cnt   <= w_first_tick ? ONE : '0;
                        end
                    end
                    MEAS_HIGH: begin
                        if (w_fall) begin
                            r_hi_latch <= r_cnt;
                            r_state    <= MEAS_LOW;
                        end
                        if (!w_fall && w_tick && w_cnt_max) begin
                            r_ovf   <= 1'b1;
                            r_state <= WAIT_RISE;
                            r_pre   <= '0;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            r_pre <= '0;
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_pre <= w_pre_inc;
                        end
                    end
                    MEAS_LOW: begin
                        if (w_rise) begin
                            r_period <= r_cnt;
                            r_high   <= r_hi_latch;
                            r_valid  <= 1'b1;
                            if (r_oneshot) begin
                                r_state <= IDLE;
                                r_en    <= 1'b0;
                                r_pre   <= '0;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= MEAS_HIGH;
                                r_pre   <= w_first_tick ? '0 : ONE;
                                r_cnt   <= w_first_tick ? ONE : '0;
                            end
                        end else if (w_tick && w_cnt_max) begin
                            r_ovf   <= 1'b1;
                            r_state <= WAIT_RISE;
                            r_pre   <= '0;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            r_pre <= '0;
                            r_cnt <= w_cnt_inc;
                        end else begin
                            r_pre <= w_pre_inc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign intr_o = r_intr;

    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            8'h00:   bus.rdata_o = {29'd0, r_oneshot, r_ie, r_en};
            8'h04:   bus.rdata_o = 32'(r_divisor);
            8'h08:   bus.rdata_o = 32'(r_period);
            8'h0C:   bus.rdata_o = 32'(r_high);
            8'h10:   bus.rdata_o = {29'd0, w_sync, r_ovf, r_valid};
            default: bus.rdata_o = '0;
        endcase
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected PERIOD/HIGH pairs are queued as each
// PWM pattern is started and popped when the block reports a valid capture.
module tb_pwm_capture;
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_DIV  = 8'h04;
    localparam logic [7:0] A_PER  = 8'h08;
    localparam logic [7:0] A_HI   = 8'h0C;
    localparam logic [7:0] A_STAT = 8'h10;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm = 1'b0;
    logic intr;
    pwm_capture_if bus ();

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    int gen_mode = 0;
    int gen_per = 100;
    int gen_hi = 30;
    int gen_ph = 0;

    pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .pwm_i  (pwm),
        .intr_o (intr)
    );

    always #5 clk = ~clk;

    // Pin generator: mode 0 low, 1 PWM (period/high in clk cycles), 2 held high.
    initial begin
        forever begin
            @(negedge clk);
            if (gen_mode == 1) begin
                pwm = (gen_ph < gen_hi);
                gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
            end else begin
                pwm = (gen_mode == 2);
                gen_ph = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr_i = a;
        bus.wdata_i = d;
        bus.re_i = 1'b0;
        bus.we_i = 1'b1;
        @(negedge clk);
        bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr_i = a;
        bus.re_i = 1'b1;
        #1;
        d = bus.rdata_o;
        bus.re_i = 1'b0;
    endtask

    task automatic start_pwm(input int per, input int hi);
        gen_mode = 0;
        repeat (4) @(negedge clk);
        gen_per = per;
        gen_hi = hi;
        gen_mode = 1;
    endtask

    task automatic push_exp(input int per, input int hi, input int d);
        exp_t e;
        e.per = per / d;
        e.hi = hi / d;
        exp_q.push_back(e);
    endtask

    task automatic wait_pin(input string tag, input logic lvl, input int limit);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            rd(A_STAT, d);
            if (d[2] == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_pin_wait"}, 32'(ok), 32'd1);
    endtask

    // Polls every cycle for valid, checks the one-cycle interrupt lag, then pops and compares.
    task automatic collect(input string tag, input int limit, input logic ie);
        logic [31:0] d;
        exp_t e;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            rd(A_STAT, d);
            if (d[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_valid"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, "_intr_lag"}, 32'(intr), 32'd0);
            @(negedge clk);
            #1;
            chk({tag, "_intr"}, 32'(intr), 32'(ie));
        end
        e = exp_q.pop_front();
        rd(A_PER, d);
        chk({tag, "_period"}, d, 32'(e.per));
        rd(A_HI, d);
        chk({tag, "_high"}, d, 32'(e.hi));
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0] addrs [5];
        bit ok;
        addrs[0] = A_CTRL; addrs[1] = A_DIV; addrs[2] = A_PER; addrs[3] = A_HI; addrs[4] = A_STAT;
        bus.re_i = 1'b0;
        bus.we_i = 1'b0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        bus.be_i = 4'hF;

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.addr_i = addrs[i];
            #1;
            chk($sformatf("reset_rd_%0h", addrs[i]), bus.rdata_o, 32'd0);
        end
        chk("reset_intr", 32'(intr), 32'd0);
        rst_n = 1'b1;

        // A write with re_i also high must be ignored
        @(negedge clk);
        bus.addr_i = A_CTRL;
        bus.wdata_i = 32'h7;
        bus.re_i = 1'b1;
        bus.we_i = 1'b1;
        @(negedge clk);
        bus.we_i = 1'b0;
        bus.re_i = 1'b0;
        rd(A_CTRL, d);
        chk("re_we_blocked", d, 32'd0);

        // 1: D=1, 100/30, interrupt and W1C
        wr(A_DIV, 32'd1);
        start_pwm(100, 30);
        wr(A_CTRL, 32'h3);
        push_exp(100, 30, 1);
        collect("t1a", 400, 1'b1);
        rd(A_STAT, d);
        chk("t1_stat", d & 32'h3, 32'h1);
        rd(8'h14, d);
        chk("t1_unmapped", d, 32'd0);
        wr(A_STAT, 32'h1);
        bus.addr_i = A_STAT;
        #1;
        chk("t1_w1c_valid", bus.rdata_o & 32'h1, 32'd0);
        chk("t1_intr_hold", 32'(intr), 32'd1);
        @(negedge clk);
        #1;
        chk("t1_intr_drop", 32'(intr), 32'd0);
        push_exp(100, 30, 1);
        collect("t1b", 200, 1'b1);

        // 2: prescaled and DIVISOR=0
        wr(A_CTRL, 32'h0);
        wr(A_DIV, 32'd4);
        start_pwm(400, 100);
        wr(A_STAT, 32'h3);
        wr(A_CTRL, 32'h3);
        push_exp(400, 100, 4);
        collect("t2a", 1500, 1'b1);
        wr(A_CTRL, 32'h0);
        wr(A_DIV, 32'd0);
        start_pwm(50, 20);
        wr(A_STAT, 32'h3);
        wr(A_CTRL, 32'h1);
        push_exp(50, 20, 1);
        collect("t2b", 300, 1'b0);

        // 3: held high after one rise -> overflow
        wr(A_CTRL, 32'h0);
        gen_mode = 0;
        repeat (6) @(negedge clk);
        wr(A_STAT, 32'h3);
        wr(A_DIV, 32'd1);
        wr(A_CTRL, 32'h1);
        gen_mode = 2;
        repeat (65000) @(negedge clk);
        rd(A_STAT, d);
        chk("t3_no_early_ovf", d & 32'h3, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rd(A_STAT, d);
            if (d[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t3_ovf_set", 32'(ok), 32'd1);
        rd(A_STAT, d);
        chk("t3_stat", d, 32'h6);
        rd(A_PER, d);
        chk("t3_period_kept", d, 32'd50);
        rd(A_HI, d);
        chk("t3_high_kept", d, 32'd20);
        wr(A_STAT, 32'h2);
        rd(A_STAT, d);
        chk("t3_ovf_clr", d, 32'h4);
        start_pwm(100, 30);
        push_exp(100, 30, 1);
        collect("t3", 400, 1'b0);

        // 4: oneshot
        wr(A_CTRL, 32'h0);
        start_pwm(80, 50);
        wr(A_STAT, 32'h3);
        wr(A_CTRL, 32'h5);
        push_exp(80, 50, 1);
        collect("t4", 300, 1'b0);
        gen_per = 60;
        gen_hi = 10;
        rd(A_CTRL, d);
        chk("t4_ctrl", d, 32'h4);
        wr(A_STAT, 32'h1);
        repeat (300) @(negedge clk);
        rd(A_STAT, d);
        chk("t4_no_valid", d & 32'h3, 32'd0);
        rd(A_PER, d);
        chk("t4_period_kept", d, 32'd80);
        rd(A_HI, d);
        chk("t4_high_kept", d, 32'd50);

        // 5: disable mid MEAS_LOW, re-enable
        start_pwm(200, 20);
        wr(A_STAT, 32'h3);
        wr(A_CTRL, 32'h1);
        push_exp(200, 20, 1);
        collect("t5a", 700, 1'b0);
        wr(A_STAT, 32'h1);
        wait_pin("t5_hi", 1'b1, 300);
        wait_pin("t5_lo", 1'b0, 300);
        repeat (50) @(negedge clk);
        wr(A_CTRL, 32'h0);
        repeat (10) @(negedge clk);
        wr(A_CTRL, 32'h1);
        rd(A_STAT, d);
        chk("t5_reen_valid", d & 32'h1, 32'd0);
        wait_pin("t5_rise", 1'b1, 300);
        repeat (10) @(negedge clk);
        rd(A_STAT, d);
        chk("t5_no_early_valid", d & 32'h1, 32'd0);
        rd(A_PER, d);
        chk("t5_period_kept", d, 32'd200);
        push_exp(200, 20, 1);
        collect("t5b", 300, 1'b0);

        // 6: reset mid-measurement
        wr(A_CTRL, 32'h3);
        wait_pin("t6_hi", 1'b1, 300);
        wait_pin("t6_lo", 1'b0, 300);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.addr_i = addrs[i];
            #1;
            chk($sformatf("t6_rst_rd_%0h", addrs[i]), bus.rdata_o, 32'd0);
        end
        chk("t6_rst_intr", 32'(intr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr(A_CTRL, 32'h3);
        wait_pin("t6_rise", 1'b1, 300);
        repeat (10) @(negedge clk);
        rd(A_STAT, d);
        chk("t6_no_early_valid", d & 32'h1, 32'd0);
        push_exp(200, 20, 1);
        collect("t6", 300, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
